// File: rtl/pulse_param_decoder.sv
// Framed UART command decoder staging pulse-generator parameters in shadow registers and publishing them atomically on commit.
// Optional build macro PARAM_READBACK_EN adds 0x81-0x88 register readback frames.
module pulse_param_decoder #(
    parameter logic [31:0] DEF_PERIOD = 32'd600000,
    parameter logic [31:0] DEF_P1WID  = 32'd30,
    parameter logic [31:0] DEF_DEL    = 32'd200,
    parameter logic [31:0] DEF_P2WID  = 32'd60,
    parameter int          TIMEOUT    = 120000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] per,
    output logic [31:0] p1wid,
    output logic [31:0] del,
    output logic [31:0] p2wid,
    output logic        pu,
    output logic        bl,
    output logic [7:0]  cp,
    output logic [7:0]  p_bl,
    output logic [15:0] p_bl_off,
    output logic        upd
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT);
    localparam logic [7:0]    SOF      = 8'hA5;
    localparam logic [7:0]    ACK      = 8'h06;
    localparam logic [7:0]    NAK      = 8'h15;

    logic [2:0]    state;
    logic [1:0]    cnt;
    logic [TW-1:0] tout;
    logic          exec;
    logic [7:0]    addr;
    logic [7:0]    chk_acc;
    logic [31:0]   data;
    logic          chk_ok;

    logic [31:0] sh_per, sh_p1wid, sh_del, sh_p2wid;
    logic        sh_pu, sh_bl;
    logic [7:0]  sh_cp, sh_p_bl;
    logic [15:0] sh_p_bl_off;

    logic wr_map, commit, rd_hit, frame_ok, handshake;

    assign wr_map    = (addr >= 8'h01) && (addr <= 8'h08);
    assign commit    = (addr == 8'h0F);
    assign frame_ok  = chk_ok && (wr_map || commit || rd_hit);
    assign handshake = tx_valid && tx_ready;

`ifdef PARAM_READBACK_EN
    logic [31:0] rd_val;
    logic [31:0] rb_word;
    logic [2:0]  rb_left;

    assign rd_hit = addr[7] && (addr[6:0] >= 7'd1) && (addr[6:0] <= 7'd8);

    always_comb begin
        rd_val = '0;
        case (addr[6:0])
            7'd1:    rd_val = per;
            7'd2:    rd_val = p1wid;
            7'd3:    rd_val = del;
            7'd4:    rd_val = p2wid;
            7'd5:    rd_val = {30'd0, bl, pu};
            7'd6:    rd_val = {24'd0, cp};
            7'd7:    rd_val = {24'd0, p_bl};
            7'd8:    rd_val = {16'd0, p_bl_off};
            default: rd_val = '0;
        endcase
    end

    // Readback payload shifts out MSB first, one byte per accepted handshake.
    always_ff @(posedge clk) begin
        if (state == S_RESP && exec)
            rb_word <= rd_val;
        else if (state == S_RESP && handshake && rb_left != 3'd0)
            rb_word <= {rb_word[23:0], 8'h00};
    end
`else
    assign rd_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= 2'd0;
            tout     <= '0;
            exec     <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            upd      <= 1'b0;
`ifdef PARAM_READBACK_EN
            rb_left  <= 3'd0;
`endif
        end else begin
            upd <= 1'b0;
            case (state)
                S_IDLE: begin
                    tout <= '0;
                    if (rx_valid && rx_data == SOF)
                        state <= S_ADDR;
                end
                S_ADDR, S_DATA, S_CHK: begin
                    if (rx_valid) begin
                        tout <= '0;
                        case (state)
                            S_ADDR: begin
                                state <= S_DATA;
                                cnt   <= 2'd0;
                            end
                            S_DATA: begin
                                cnt <= cnt + 2'd1;
                                if (cnt == 2'd3)
                                    state <= S_CHK;
                            end
                            default: begin
                                state <= S_RESP;
                                exec  <= 1'b1;
                            end
                        endcase
                    end else if (tout == TOUT_MAX) begin
                        state <= S_IDLE;
                        tout  <= '0;
                    end else begin
                        tout <= tout + TW'(1);
                    end
                end
                S_RESP: begin
                    // Frame is evaluated one edge after its CHK byte; incoming bytes are ignored here.
                    if (exec) begin
                        exec     <= 1'b0;
                        tx_valid <= 1'b1;
                        tx_data  <= frame_ok ? ACK : NAK;
                        if (frame_ok && commit)
                            upd <= 1'b1;
`ifdef PARAM_READBACK_EN
                        if (frame_ok && rd_hit)
                            rb_left <= 3'd4;
`endif
                    end else if (handshake) begin
`ifdef PARAM_READBACK_EN
                        if (rb_left != 3'd0) begin
                            tx_data <= rb_word[31:24];
                            rb_left <= rb_left - 3'd1;
                        end else begin
                            tx_valid <= 1'b0;
                            state    <= S_IDLE;
                        end
`else
                        tx_valid <= 1'b0;
                        state    <= S_IDLE;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_ADDR && rx_valid) begin
            addr    <= rx_data;
            chk_acc <= rx_data;
        end else if (state == S_DATA && rx_valid) begin
            data    <= {data[23:0], rx_data};
            chk_acc <= chk_acc ^ rx_data;
        end else if (state == S_CHK && rx_valid) begin
            chk_ok  <= (rx_data == chk_acc);
        end
    end

    // Shadow writes and the commit copy both land on the evaluation edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_per      <= DEF_PERIOD;
            sh_p1wid    <= DEF_P1WID;
            sh_del      <= DEF_DEL;
            sh_p2wid    <= DEF_P2WID;
            sh_pu       <= 1'b0;
            sh_bl       <= 1'b0;
            sh_cp       <= 8'd0;
            sh_p_bl     <= 8'd0;
            sh_p_bl_off <= 16'd0;
            per         <= DEF_PERIOD;
            p1wid       <= DEF_P1WID;
            del         <= DEF_DEL;
            p2wid       <= DEF_P2WID;
            pu          <= 1'b0;
            bl          <= 1'b0;
            cp          <= 8'd0;
            p_bl        <= 8'd0;
            p_bl_off    <= 16'd0;
        end else if (state == S_RESP && exec && frame_ok) begin
            if (commit) begin
                per      <= sh_per;
                p1wid    <= sh_p1wid;
                del      <= sh_del;
                p2wid    <= sh_p2wid;
                pu       <= sh_pu;
                bl       <= sh_bl;
                cp       <= sh_cp;
                p_bl     <= sh_p_bl;
                p_bl_off <= sh_p_bl_off;
            end else if (wr_map) begin
                case (addr)
                    8'h01:   sh_per      <= data;
                    8'h02:   sh_p1wid    <= data;
                    8'h03:   sh_del      <= data;
                    8'h04:   sh_p2wid    <= data;
                    8'h05: begin
                             sh_bl       <= data[1];
                             sh_pu       <= data[0];
                    end
                    8'h06:   sh_cp       <= data[7:0];
                    8'h07:   sh_p_bl     <= data[7:0];
                    default: sh_p_bl_off <= data[15:0];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_param_decoder.sv
// Scoreboard bench for pulse_param_decoder: a frame-level model queues expected response bytes, a monitor checks each handshake.
module tb_pulse_param_decoder;

    localparam int TO = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] per, p1wid, del, p2wid;
    logic        pu, bl;
    logic [7:0]  cp, p_bl;
    logic [15:0] p_bl_off;
    logic        upd;

    always #5 clk = ~clk;

    pulse_param_decoder #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
        .pu(pu), .bl(bl), .cp(cp), .p_bl(p_bl), .p_bl_off(p_bl_off), .upd(upd)
    );

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];
    int          upd_cnt = 0;
    int          exp_upd = 0;
    logic        upd_prev = 1'b0;
    logic [31:0] m_sh[16];
    logic [31:0] m_act[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_tx: got 0x%0h, expected no response", tx_data);
                end else begin
                    check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (upd) begin
                upd_cnt++;
                if (upd_prev) begin
                    tests++;
                    fails++;
                    $display("FAIL upd_width: got upd high 2 cycles, expected 1");
                end
            end
            upd_prev = upd;
        end else begin
            upd_prev = 1'b0;
        end
    end

    function automatic logic [31:0] wmask(input logic [7:0] a);
        case (a)
            8'h05:        return 32'h3;
            8'h06, 8'h07: return 32'hFF;
            8'h08:        return 32'hFFFF;
            default:      return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_sh[i]  = 32'd0;
            m_act[i] = 32'd0;
        end
        m_sh[1] = 32'd600000; m_sh[2] = 32'd30; m_sh[3] = 32'd200; m_sh[4] = 32'd60;
        for (int i = 0; i < 16; i++) m_act[i] = m_sh[i];
    endtask

    task automatic model_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] chk);
        logic [7:0]  x;
        logic        good, mapped, rd;
        logic [31:0] v;
        x      = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
        good   = (chk == x);
        rd     = a[7] && (a[6:0] >= 7'd1) && (a[6:0] <= 7'd8);
        mapped = ((a >= 8'h01) && (a <= 8'h08)) || (a == 8'h0F);
`ifdef PARAM_READBACK_EN
        mapped = mapped || rd;
`endif
        if (!(good && mapped)) begin
            exp_q.push_back(8'h15);
        end else if (a == 8'h0F) begin
            for (int i = 0; i < 16; i++) m_act[i] = m_sh[i];
            exp_upd++;
            exp_q.push_back(8'h06);
        end else if (rd) begin
            v = m_act[a[3:0]];
            exp_q.push_back(8'h06);
            for (int k = 3; k >= 0; k--) exp_q.push_back(v[8*k +: 8]);
        end else begin
            m_sh[a[3:0]] = d & wmask(a);
            exp_q.push_back(8'h06);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] a, input logic [31:0] d, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(a);
        for (int k = 3; k >= 0; k--) send_byte(d[8*k +: 8]);
        send_byte(chk);
    endtask

    task automatic drain(input bit rand_rdy);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !tx_valid) && n < 3000) begin
            tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            idle(1);
            n++;
        end
        tx_ready = 1'b1;
        if (n >= 3000) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d bytes outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        idle(1);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input bit bad, input bit rand_rdy);
        logic [7:0] chk;
        chk = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
        if (bad) chk = chk ^ (8'h01 << $urandom_range(0, 7));
        model_frame(a, d, chk);
        send_raw(a, d, chk);
        drain(rand_rdy);
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".per"},      per,                  m_act[1]);
        check({tag, ".p1wid"},    p1wid,                m_act[2]);
        check({tag, ".del"},      del,                  m_act[3]);
        check({tag, ".p2wid"},    p2wid,                m_act[4]);
        check({tag, ".bl_pu"},    {30'd0, bl, pu},      m_act[5]);
        check({tag, ".cp"},       {24'd0, cp},          m_act[6]);
        check({tag, ".p_bl"},     {24'd0, p_bl},        m_act[7]);
        check({tag, ".p_bl_off"}, {16'd0, p_bl_off},    m_act[8]);
        check({tag, ".upd_cnt"},  upd_cnt,              exp_upd);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        exp_upd = 0;
        upd_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] drop_seq[7];
        logic [7:0] a;
        logic [7:0] addr_pool[12];
        drop_seq  = '{8'hA5, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F};
        addr_pool = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                      8'h0F, 8'h0F, 8'h00, 8'h09};
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        idle(3);
        reset = 1'b0;
        idle(1);

        check("reset.tx_valid", {31'd0, tx_valid}, 32'd0);
        check("reset.tx_data",  {24'd0, tx_data},  32'd0);
        check("reset.upd",      {31'd0, upd},      32'd0);
        check_outs("reset");

        send_frame(8'h01, 32'd10000, 1'b0, 1'b0);
        check_outs("write_per");
        send_frame(8'h0F, 32'd0, 1'b0, 1'b0);
        check_outs("commit1");

        model_frame(8'h02, 32'h10, 8'h13);
        send_raw(8'h02, 32'h10, 8'h13);
        drain(1'b0);
        send_frame(8'h0F, 32'd0, 1'b0, 1'b0);
        check_outs("bad_chk");

        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
        idle(TO + 10);
        send_frame(8'h05, 32'd3, 1'b0, 1'b0);
        send_frame(8'h0F, 32'd0, 1'b0, 1'b0);
        check_outs("timeout");

        tx_ready = 1'b0;
        model_frame(8'h06, 32'h5A, 8'h06 ^ 8'h5A);
        send_raw(8'h06, 32'h5A, 8'h06 ^ 8'h5A);
        check("latency.tx_valid_N", {31'd0, tx_valid}, 32'd0);
        idle(1);
        check("latency.tx_valid_N1", {31'd0, tx_valid}, 32'd1);
        for (int i = 0; i < 50; i++) begin
            send_byte(drop_seq[i % 7]);
            check("stall.tx_valid", {31'd0, tx_valid}, 32'd1);
            check("stall.tx_data",  {24'd0, tx_data},  {24'd0, exp_q[0]});
        end
        drain(1'b0);
        send_frame(8'h0F, 32'd0, 1'b0, 1'b0);
        check_outs("stall");

        send_frame(8'h81, 32'd0, 1'b0, 1'b0);
        send_frame(8'h85, 32'd0, 1'b0, 1'b1);
        check_outs("readback");

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 8'($urandom_range(0, 255));
                1:       a = 8'h80 | 8'($urandom_range(1, 8));
                default: a = addr_pool[$urandom_range(0, 11)];
            endcase
            repeat ($urandom_range(0, 2)) begin
                rx_data = 8'($urandom_range(0, 255));
                send_byte(rx_data == 8'hA5 ? 8'h00 : rx_data);
            end
            send_frame(a, $urandom, ($urandom_range(0, 5) == 0), 1'b1);
            check_outs("random");
        end

        tx_ready = 1'b0;
        send_raw(8'h01, 32'd7, 8'h01 ^ 8'h07);
        idle(3);
        check("pre_reset.tx_valid", {31'd0, tx_valid}, 32'd1);
        do_reset();
        idle(1);
        check("rst_resp.tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_resp.tx_data",  {24'd0, tx_data},  32'd0);
        tx_ready = 1'b1;
        check_outs("rst_resp");

        send_frame(8'h02, 32'd99, 1'b0, 1'b0);
        send_frame(8'h07, 32'h1234_56AB, 1'b0, 1'b0);
        send_frame(8'h0F, 32'd0, 1'b0, 1'b0);
        check_outs("pre_midframe");
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        do_reset();
        idle(1);
        check_outs("rst_frame");
        send_frame(8'h08, 32'hDEAD_BEEF, 1'b0, 1'b0);
        send_frame(8'h0F, 32'd0, 1'b0, 1'b0);
        check_outs("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
